// File: rtl/usb_rx_bit_sequencer.sv
// USB full-speed receive bit sequencer: mid-bit sampling, destuffing, byte boundary marking.
// Latency: shift_enable and stuff_error one cycle after the sample point; byte_received one cycle after the 8th shift_enable.
// Backpressure: none; the bit rate is set by the line, and every output is a one-cycle registered pulse.
module usb_rx_bit_sequencer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_PT    = 3,
   parameter int STUFF_LEN    = 6
) (
   input  logic clk,
   input  logic n_rst,
   input  logic rcving,
   input  logic d_edge,
   input  logic d_bit,
   output logic shift_enable,
   output logic byte_received,
   output logic stuff_error
);

   localparam int PHASE_W = $clog2(CLKS_PER_BIT);
   localparam int ONES_W  = $clog2(STUFF_LEN + 1);

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CLKS_PER_BIT - 1);
   localparam logic [PHASE_W-1:0] SAMPLE_PH  = PHASE_W'(SAMPLE_PT);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
   localparam logic [ONES_W-1:0]  STUFF_CNT  = ONES_W'(STUFF_LEN);
   localparam logic [ONES_W-1:0]  ONES_ONE   = ONES_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [ONES_W-1:0]   ones_cnt_q, ones_cnt_d;
   logic                stuff_pend_q, stuff_pend_d;
   logic                byte_pend_q, byte_pend_d;
   logic                shift_enable_q, shift_enable_d;
   logic                byte_received_q, byte_received_d;
   logic                stuff_error_q, stuff_error_d;

   // Per-cycle working values
   logic [PHASE_W-1:0]  eff;
   logic                sample;
   logic [ONES_W-1:0]   ones_new;

   // Next-state, counter and output-pulse computation
   always_comb begin
      state_d         = state_q;
      phase_d         = phase_q;
      bit_cnt_d       = bit_cnt_q;
      ones_cnt_d      = ones_cnt_q;
      stuff_pend_d    = stuff_pend_q;
      byte_pend_d     = 1'b0;
      shift_enable_d  = 1'b0;
      // A byte boundary scheduled last cycle fires regardless of rcving.
      byte_received_d = byte_pend_q;
      stuff_error_d   = 1'b0;
      eff             = '0;
      sample          = 1'b0;
      ones_new        = '0;

      case (state_q)
         IDLE: begin
            if (rcving) begin
               // The rcving rise is bit phase 0, edge or not.
               state_d = RUN;
               eff     = '0;
               sample  = (eff == SAMPLE_PH);
               phase_d = (eff == LAST_PHASE) ? '0 : eff + PHASE_ONE;
            end
         end
         RUN: begin
            if (!rcving) begin
               // Leaving the packet: any sample this cycle is dropped.
               state_d      = IDLE;
               phase_d      = '0;
               bit_cnt_d    = '0;
               ones_cnt_d   = '0;
               stuff_pend_d = 1'b0;
            end else begin
               // Any line transition resynchronises the bit phase.
               eff     = d_edge ? '0 : phase_q;
               sample  = (eff == SAMPLE_PH);
               phase_d = (eff == LAST_PHASE) ? '0 : eff + PHASE_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (sample) begin
         if (!stuff_pend_q) begin
            // Data bit: shift it and track the run of ones.
            shift_enable_d = 1'b1;
            ones_new       = d_bit ? ones_cnt_q + ONES_ONE : '0;
            if (ones_new == STUFF_CNT) begin
               stuff_pend_d = 1'b1;
               ones_cnt_d   = '0;
            end else begin
               ones_cnt_d   = ones_new;
            end
            if (bit_cnt_q == 3'd7) begin
               bit_cnt_d   = 3'd0;
               byte_pend_d = 1'b1;
            end else begin
               bit_cnt_d   = bit_cnt_q + 3'd1;
            end
         end else begin
            // Stuffed bit: discard; a 1 here is a stuff violation.
            stuff_pend_d  = 1'b0;
            ones_cnt_d    = '0;
            stuff_error_d = d_bit;
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q         <= IDLE;
         phase_q         <= '0;
         bit_cnt_q       <= '0;
         ones_cnt_q      <= '0;
         stuff_pend_q    <= 1'b0;
         byte_pend_q     <= 1'b0;
         shift_enable_q  <= 1'b0;
         byte_received_q <= 1'b0;
         stuff_error_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         bit_cnt_q       <= bit_cnt_d;
         ones_cnt_q      <= ones_cnt_d;
         stuff_pend_q    <= stuff_pend_d;
         byte_pend_q     <= byte_pend_d;
         shift_enable_q  <= shift_enable_d;
         byte_received_q <= byte_received_d;
         stuff_error_q   <= stuff_error_d;
      end
   end

   assign shift_enable  = shift_enable_q;
   assign byte_received = byte_received_q;
   assign stuff_error   = stuff_error_q;

endmodule

// File: tb/tb_usb_rx_bit_sequencer.sv
// Directed bench for usb_rx_bit_sequencer with default parameters.
// Latency: outputs are recorded per cycle into bit vectors and compared against hand-derived pulse positions.
// Backpressure: not applicable.
module tb_usb_rx_bit_sequencer;

   logic clk;
   logic n_rst;
   logic rcving;
   logic d_edge;
   logic d_bit;
   logic shift_enable;
   logic byte_received;
   logic stuff_error;

   int checks;
   int failures;

   logic [127:0] se_v;
   logic [127:0] br_v;
   logic [127:0] er_v;

   usb_rx_bit_sequencer #(
      .CLKS_PER_BIT(8),
      .SAMPLE_PT   (3),
      .STUFF_LEN   (6)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .rcving       (rcving),
      .d_edge       (d_edge),
      .d_bit        (d_bit),
      .shift_enable (shift_enable),
      .byte_received(byte_received),
      .stuff_error  (stuff_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      se_v = '0;
      br_v = '0;
      er_v = '0;
   endtask

   // Record this cycle's outputs at index c, then advance one clock.
   task automatic step(input int c);
      se_v[c] = shift_enable;
      br_v[c] = byte_received;
      er_v[c] = stuff_error;
      tick();
   endtask

   task automatic idle_gap();
      rcving = 1'b0;
      d_edge = 1'b0;
      d_bit  = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      n_rst  = 1'b0;
      rcving = 1'b1;
      d_edge = 1'b1;
      d_bit  = 1'b1;
      repeat (3) tick();
      checks++;
      if (shift_enable !== 1'b0) begin
         failures++;
         $display("FAIL reset_shift_enable got=%b exp=0", shift_enable);
      end
      checks++;
      if (byte_received !== 1'b0) begin
         failures++;
         $display("FAIL reset_byte_received got=%b exp=0", byte_received);
      end
      checks++;
      if (stuff_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_stuff_error got=%b exp=0", stuff_error);
      end
      rcving = 1'b0;
      d_edge = 1'b0;
      d_bit  = 1'b0;
      n_rst  = 1'b1;
      repeat (3) tick();
      checks++;
      if ({shift_enable, byte_received, stuff_error} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset got=%b exp=000",
                  {shift_enable, byte_received, stuff_error});
      end
   endtask

   // No edges, d_bit=0; rcving drops in the 8th shift cycle so the pending byte must still fire.
   task automatic test_basic();
      logic [127:0] exp_se, exp_br, exp_er;
      exp_se = '0; exp_br = '0; exp_er = '0;
      for (int k = 0; k < 8; k++) exp_se[4 + 8*k] = 1'b1;
      exp_br[61] = 1'b1;
      clear_rec();
      d_bit = 1'b0; d_edge = 1'b0;
      for (int c = 0; c < 64; c++) begin
         rcving = (c < 60);
         step(c);
      end
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL basic_shift_enable got=%h exp=%h", se_v, exp_se);
      end
      checks++;
      if (br_v !== exp_br) begin
         failures++;
         $display("FAIL basic_byte_received got=%h exp=%h", br_v, exp_br);
      end
      checks++;
      if (er_v !== exp_er) begin
         failures++;
         $display("FAIL basic_stuff_error got=%h exp=%h", er_v, exp_er);
      end
      idle_gap();
   endtask

   // Edge at cycle 10 (phase 2) moves the sample to 13 and shift_enable to 14, then 22.
   task automatic test_resync();
      logic [127:0] exp_se, exp_br;
      exp_se = '0; exp_br = '0;
      exp_se[4] = 1'b1; exp_se[14] = 1'b1; exp_se[22] = 1'b1;
      clear_rec();
      d_bit = 1'b0;
      for (int c = 0; c < 30; c++) begin
         rcving = 1'b1;
         d_edge = (c == 10);
         step(c);
      end
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL resync_shift_enable got=%h exp=%h", se_v, exp_se);
      end
      checks++;
      if (br_v !== exp_br) begin
         failures++;
         $display("FAIL resync_byte_received got=%h exp=%h", br_v, exp_br);
      end
      idle_gap();
   endtask

   // Edge exactly at the sample cycle suppresses that sample; next samples at 6 and 14.
   task automatic test_edge_at_sample();
      logic [127:0] exp_se;
      exp_se = '0;
      exp_se[7] = 1'b1; exp_se[15] = 1'b1;
      clear_rec();
      d_bit = 1'b0;
      for (int c = 0; c < 20; c++) begin
         rcving = 1'b1;
         d_edge = (c == 3);
         step(c);
      end
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL edge_at_sample_shift_enable got=%h exp=%h", se_v, exp_se);
      end
      idle_gap();
   endtask

   // Six 1s then a stuffed bit (0 or 1), then 0s. Byte boundary after the 8th non-stuffed bit.
   task automatic test_stuffing(input logic stuffed_val);
      logic [15:0]  bits;
      logic [127:0] exp_se, exp_br, exp_er;
      bits = 16'h003F;
      bits[6] = stuffed_val;
      exp_se = '0; exp_br = '0; exp_er = '0;
      for (int b = 0; b < 9; b++) if (b != 6) exp_se[8*b + 4] = 1'b1;
      exp_br[69] = 1'b1;
      if (stuffed_val) exp_er[52] = 1'b1;
      clear_rec();
      d_edge = 1'b0;
      for (int c = 0; c < 72; c++) begin
         rcving = 1'b1;
         d_bit  = bits[c/8];
         step(c);
      end
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL stuff%0d_shift_enable got=%h exp=%h", stuffed_val, se_v, exp_se);
      end
      checks++;
      if (br_v !== exp_br) begin
         failures++;
         $display("FAIL stuff%0d_byte_received got=%h exp=%h", stuffed_val, br_v, exp_br);
      end
      checks++;
      if (er_v !== exp_er) begin
         failures++;
         $display("FAIL stuff%0d_stuff_error got=%h exp=%h", stuffed_val, er_v, exp_er);
      end
      idle_gap();
   endtask

   // rcving drops in the 6th sample cycle (43); new packet at 48 counts 8 fresh bits.
   task automatic test_drop_restart();
      logic [127:0] exp_se, exp_br;
      exp_se = '0; exp_br = '0;
      for (int k = 0; k < 5; k++) exp_se[4 + 8*k] = 1'b1;
      for (int k = 0; k < 8; k++) exp_se[52 + 8*k] = 1'b1;
      exp_br[109] = 1'b1;
      clear_rec();
      d_bit = 1'b0; d_edge = 1'b0;
      for (int c = 0; c < 112; c++) begin
         rcving = (c < 43) || (c >= 48);
         step(c);
      end
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL drop_shift_enable got=%h exp=%h", se_v, exp_se);
      end
      checks++;
      if (br_v !== exp_br) begin
         failures++;
         $display("FAIL drop_byte_received got=%h exp=%h", br_v, exp_br);
      end
      idle_gap();
   endtask

   // Reset held one cycle at the 5th sample point (35); restart at 40 behaves as from cold.
   task automatic test_reset_mid_run();
      logic [127:0] exp_se, exp_br, exp_er;
      exp_se = '0; exp_br = '0; exp_er = '0;
      for (int k = 0; k < 4; k++) exp_se[4 + 8*k] = 1'b1;
      for (int k = 0; k < 8; k++) exp_se[44 + 8*k] = 1'b1;
      exp_br[101] = 1'b1;
      clear_rec();
      d_edge = 1'b0;
      for (int c = 0; c < 104; c++) begin
         n_rst  = (c != 35);
         rcving = (c < 36) || (c >= 40);
         d_bit  = (c < 36) ? 1'b1 : 1'b0;
         step(c);
      end
      n_rst = 1'b1;
      checks++;
      if (se_v !== exp_se) begin
         failures++;
         $display("FAIL rst_mid_shift_enable got=%h exp=%h", se_v, exp_se);
      end
      checks++;
      if (br_v !== exp_br) begin
         failures++;
         $display("FAIL rst_mid_byte_received got=%h exp=%h", br_v, exp_br);
      end
      checks++;
      if (er_v !== exp_er) begin
         failures++;
         $display("FAIL rst_mid_stuff_error got=%h exp=%h", er_v, exp_er);
      end
      idle_gap();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      n_rst    = 1'b0;
      rcving   = 1'b0;
      d_edge   = 1'b0;
      d_bit    = 1'b0;
      clear_rec();
      #1;
      test_reset();
      test_basic();
      test_resync();
      test_edge_at_sample();
      test_stuffing(1'b0);
      test_stuffing(1'b1);
      test_drop_restart();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
